// File: rtl/billiard_pkg.sv
// Shared types and constants for the billiard ball engine: motion states,
// the signed velocity word, and the default fixed-point and table limits.
package billiard_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        SUNK   = 2'd2
    } motion_state_t;

    typedef logic signed [10:0] vel_t;

    localparam int FRAC_BITS_DEFAULT   = 4;
    localparam int POS_INT_BITS        = 11;
    localparam int FRICTION_PERIOD_MIN = 1;
    localparam int FRICTION_PERIOD_MAX = 255;
    localparam int TABLE_MAX_X         = 623;
    localparam int TABLE_MAX_Y         = 463;

endpackage

// File: rtl/vel_friction.sv
// One velocity component pulled one unit toward zero when friction fires.
// A zero component stays zero, so friction can never reverse a ball.
module vel_friction
    import billiard_pkg::*;
(
    input  logic signed [10:0] v_i,
    input  logic               decEn_i,
    output logic signed [10:0] v_o
);

    // Step the magnitude down by one, leaving zero untouched
    always_comb begin
        v_o = v_i;
        if (decEn_i && (v_i != '0)) begin
            if (v_i[10]) begin
                v_o = v_i + 11'sd1;
            end else begin
                v_o = v_i - 11'sd1;
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Per-ball kinematics: fixed-point position and velocity advanced once per
// frame, with friction, wall clamping, collision velocity latching, cue
// strikes and pocketing. Outputs are taken straight from registers.
module ball_motion
    import billiard_pkg::*;
#(
    parameter int INIT_X          = 100,
    parameter int INIT_Y          = 200,
    parameter int FRAC_BITS       = FRAC_BITS_DEFAULT,
    parameter int FRICTION_PERIOD = 8,
    parameter int MAX_X           = TABLE_MAX_X,
    parameter int MAX_Y           = TABLE_MAX_Y
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               collisionOccurred,
    input  logic signed [10:0] velXIn,
    input  logic signed [10:0] velYIn,
    input  logic               holeHit,
    input  logic               strikeValid,
    input  logic signed [10:0] strikeVelX,
    input  logic signed [10:0] strikeVelY,
    input  logic               respawn,
    output logic [10:0]        topLeftPosX,
    output logic [10:0]        topLeftPosY,
    output logic signed [10:0] velX,
    output logic signed [10:0] velY,
    output logic               moving,
    output logic               sunk
);

    localparam int PW = POS_INT_BITS + FRAC_BITS;
    localparam int SW = PW + 2;

    localparam logic [PW-1:0] INIT_POS_X = PW'(INIT_X * (2 ** FRAC_BITS));
    localparam logic [PW-1:0] INIT_POS_Y = PW'(INIT_Y * (2 ** FRAC_BITS));
    localparam logic [PW-1:0] MAX_POS_X  = PW'(MAX_X * (2 ** FRAC_BITS));
    localparam logic [PW-1:0] MAX_POS_Y  = PW'(MAX_Y * (2 ** FRAC_BITS));
    localparam logic [7:0]    FRIC_LAST  = 8'(FRICTION_PERIOD - 1);

    motion_state_t   state_q, state_d;
    logic [PW-1:0]   posX_q, posX_d, posY_q, posY_d;
    vel_t            velX_q, velX_d, velY_q, velY_d;
    logic            latchValid_q, latchValid_d;
    vel_t            latchVelX_q, latchVelX_d, latchVelY_q, latchVelY_d;
    logic [7:0]      fricCnt_q, fricCnt_d;

    vel_t                  tickVelX, tickVelY;
    logic signed [SW-1:0]  sumX, sumY;
    logic [PW-1:0]         clampPosX, clampPosY;
    vel_t                  clampVelX, clampVelY;
    vel_t                  fricVelX, fricVelY;
    logic                  fricWrap;
    logic                  tickEn;

    // Frame-tick datapath: pick latched or current velocity, add it to the
    // position and pin the result to the table, killing the clipped component
    always_comb begin
        tickVelX  = latchValid_q ? latchVelX_q : velX_q;
        tickVelY  = latchValid_q ? latchVelY_q : velY_q;
        sumX      = $signed({2'b00, posX_q}) + $signed({{(SW-11){tickVelX[10]}}, tickVelX});
        sumY      = $signed({2'b00, posY_q}) + $signed({{(SW-11){tickVelY[10]}}, tickVelY});
        clampPosX = sumX[PW-1:0];
        clampPosY = sumY[PW-1:0];
        clampVelX = tickVelX;
        clampVelY = tickVelY;
        if (sumX[SW-1]) begin
            clampPosX = '0;
            clampVelX = '0;
        end else if (sumX > $signed({2'b00, MAX_POS_X})) begin
            clampPosX = MAX_POS_X;
            clampVelX = '0;
        end
        if (sumY[SW-1]) begin
            clampPosY = '0;
            clampVelY = '0;
        end else if (sumY > $signed({2'b00, MAX_POS_Y})) begin
            clampPosY = MAX_POS_Y;
            clampVelY = '0;
        end
        fricWrap = (fricCnt_q == FRIC_LAST);
    end

    vel_friction uFricX (
        .v_i     (clampVelX),
        .decEn_i (fricWrap),
        .v_o     (fricVelX)
    );

    vel_friction uFricY (
        .v_i     (clampVelY),
        .decEn_i (fricWrap),
        .v_o     (fricVelY)
    );

    // Next-state logic: pocketing beats everything, a strike beats the tick
    // in IDLE, and an IDLE ball with a pending collision is ticked as moving
    always_comb begin
        state_d      = state_q;
        posX_d       = posX_q;
        posY_d       = posY_q;
        velX_d       = velX_q;
        velY_d       = velY_q;
        latchValid_d = latchValid_q;
        latchVelX_d  = latchVelX_q;
        latchVelY_d  = latchVelY_q;
        fricCnt_d    = fricCnt_q;
        tickEn       = startOfFrame && ((state_q == MOVING) || latchValid_q);

        case (state_q)
            SUNK: begin
                if (respawn) begin
                    posX_d  = INIT_POS_X;
                    posY_d  = INIT_POS_Y;
                    velX_d  = '0;
                    velY_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                if (holeHit) begin
                    state_d      = SUNK;
                    velX_d       = '0;
                    velY_d       = '0;
                    latchValid_d = 1'b0;
                end else begin
                    if ((state_q == IDLE) && strikeValid) begin
                        velX_d  = strikeVelX;
                        velY_d  = strikeVelY;
                        state_d = ((strikeVelX != '0) || (strikeVelY != '0)) ? MOVING : IDLE;
                    end else if (tickEn) begin
                        velX_d    = fricVelX;
                        velY_d    = fricVelY;
                        posX_d    = clampPosX;
                        posY_d    = clampPosY;
                        fricCnt_d = fricWrap ? 8'd0 : fricCnt_q + 8'd1;
                        state_d   = ((fricVelX != '0) || (fricVelY != '0)) ? MOVING : IDLE;
                    end

                    if (startOfFrame) begin
                        latchValid_d = collisionOccurred;
                        if (collisionOccurred) begin
                            latchVelX_d = velXIn;
                            latchVelY_d = velYIn;
                        end
                    end else if (collisionOccurred && !latchValid_q) begin
                        latchValid_d = 1'b1;
                        latchVelX_d  = velXIn;
                        latchVelY_d  = velYIn;
                    end
                end
            end
        endcase
    end

    // State, kinematics, latch and friction counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            posX_q       <= INIT_POS_X;
            posY_q       <= INIT_POS_Y;
            velX_q       <= '0;
            velY_q       <= '0;
            latchValid_q <= 1'b0;
            latchVelX_q  <= '0;
            latchVelY_q  <= '0;
            fricCnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            posX_q       <= posX_d;
            posY_q       <= posY_d;
            velX_q       <= velX_d;
            velY_q       <= velY_d;
            latchValid_q <= latchValid_d;
            latchVelX_q  <= latchVelX_d;
            latchVelY_q  <= latchVelY_d;
            fricCnt_q    <= fricCnt_d;
        end
    end

    assign topLeftPosX = posX_q[PW-1:FRAC_BITS];
    assign topLeftPosY = posY_q[PW-1:FRAC_BITS];
    assign velX        = velX_q;
    assign velY        = velY_q;
    assign moving      = (state_q == MOVING);
    assign sunk        = (state_q == SUNK);

endmodule
